// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result bundle for the pipelined adder/subtractor
interface pipelined_add_sub_if #(parameter int WIDTH = 16);
  logic stall, in_valid, cin, sub, out_valid, cout, overflow, zero;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output stall, in_valid, a, b, cin, sub, input out_valid, sum, cout, overflow, zero);
  modport slave (input stall, in_valid, a, b, cin, sub, output out_valid, sum, cout, overflow, zero);
endinterface

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: slice-per-stage ripple-carry adder/subtractor with carry, overflow and zero flags
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_add_sub_if.slave io
);
  localparam int SW = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int LO = k * SW;
    logic [WIDTH-1:LO] ua, ub;
    logic [LO+SW-1:0] ns, rs;
    logic [SW:0] t;
    logic ci, vi, rc, rv;
    if (k == 0) begin : f
      assign ua = io.a;
      assign ub = io.sub ? ~io.b : io.b;
      assign ci = io.sub ? ~io.cin : io.cin;
      assign vi = io.in_valid;
      assign ns = t[SW-1:0];
    end else begin : f
      assign ua = g[k-1].p.ra;
      assign ub = g[k-1].p.rb;
      assign ci = g[k-1].rc;
      assign vi = g[k-1].rv;
      assign ns = {t[SW-1:0], g[k-1].rs};
    end
    assign t = {1'b0, ua[LO+:SW]} + {1'b0, ub[LO+:SW]} + {{SW{1'b0}}, ci};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rc <= 1'b0;
        rv <= 1'b0;
        rs <= '0;
      end else if (!io.stall) begin
        rc <= t[SW];
        rv <= vi;
        rs <= ns;
      end
    // only the still-unresolved upper operand bits travel on
    if (k < L) begin : p
      logic [WIDTH-1:LO+SW] ra, rb;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          ra <= '0;
          rb <= '0;
        end else if (!io.stall) begin
          ra <= ua[WIDTH-1:LO+SW];
          rb <= ub[WIDTH-1:LO+SW];
        end
    end
    if (k == L) begin : o
      logic ov, z;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          ov <= 1'b0;
          z <= 1'b0;
        end else if (!io.stall) begin
          ov <= (ua[WIDTH-1] == ub[WIDTH-1]) && (ns[WIDTH-1] != ua[WIDTH-1]);
          z <= ns == '0;
        end
    end
  end
  assign io.out_valid = g[L].rv;
  assign io.sum = g[L].rs;
  assign io.cout = g[L].rc;
  assign io.overflow = g[L].o.ov;
  assign io.zero = g[L].o.z;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: scoreboard bench driving STAGES=4, 1 and 16 instances from one random stream
module tb_pipelined_add_sub;
  typedef struct {
    logic [15:0] s;
    logic c, v, z;
    int n;
  } exp_t;
  logic clk = 1'b0;
  logic rst, stall, in_valid, cin, sub;
  logic [15:0] a, b;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  task automatic chk(input int st, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL st%0d %s: got %h expected %h at %0t", st, nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s, input int n);
    exp_t e;
    int r, sr;
    r = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
    sr = s ? int'($signed(x)) - int'($signed(y)) - int'(c) : int'($signed(x)) + int'($signed(y)) + int'(c);
    e.s = 16'(r);
    e.c = s ? r >= 0 : r > 65535;
    e.v = sr > 32767 || sr < -32768;
    e.z = e.s == 16'h0;
    e.n = n;
    return e;
  endfunction
  for (genvar i = 0; i < 3; i++) begin : cfg
    localparam int ST = i == 0 ? 4 : i == 1 ? 1 : 16;
    pipelined_add_sub_if #(.WIDTH(16)) io();
    pipelined_add_sub #(.WIDTH(16), .STAGES(ST)) dut(.clk(clk), .rst(rst), .io(io));
    assign io.stall = stall;
    assign io.in_valid = in_valid;
    assign io.a = a;
    assign io.b = b;
    assign io.cin = cin;
    assign io.sub = sub;
    exp_t q[$];
    exp_t e;
    int n = 0;
    bit adv = 1'b0;
    bit due;
    logic [20:0] cur, prev;
    assign cur = {io.sum, io.cout, io.overflow, io.zero, io.out_valid};
    always @(posedge clk) begin
      adv = !rst && !stall;
      if (rst) q.delete();
      else if (!stall) begin
        n++;
        if (in_valid) q.push_back(model(a, b, cin, sub, n));
      end
    end
    always @(negedge clk) begin
      if (rst) chk(ST, "reset", 32'(cur), 0);
      else if (!adv) chk(ST, "frozen", 32'(cur), 32'(prev));
      else begin
        due = q.size() > 0 && q[0].n + ST - 1 == n;
        chk(ST, "valid", 32'(io.out_valid), 32'(due));
        if (io.out_valid && due) begin
          e = q.pop_front();
          chk(ST, "result", {io.sum, io.cout, io.overflow, io.zero}, {e.s, e.c, e.v, e.z});
        end
      end
      prev = cur;
    end
  end
  task automatic cyc(input logic iv, input logic st);
    in_valid = iv;
    stall = st;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    @(posedge clk);
    #1;
  endtask
  task automatic dir(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    a = x;
    b = y;
    cin = c;
    sub = s;
    in_valid = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0);
  endtask
  task automatic idle(input int nc);
    repeat (nc) cyc(1'b0, 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    stall = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    dir(16'h1234, 16'h0000, 1'b1, 1'b0);
    dir(16'h0005, 16'h0007, 1'b0, 1'b1);
    dir(16'h8000, 16'h0001, 1'b0, 1'b1);
    dir(16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(20);
    repeat (8) cyc(1'b1, 1'b0);
    idle(20);
    for (int i = 0; i < 20; i++) cyc(1'b1, i >= 8 && i < 11);
    idle(20);
    repeat (3) cyc(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk(4, "async rst", 32'(cfg[0].io.out_valid), 0);
    chk(1, "async rst", 32'(cfg[1].io.out_valid), 0);
    chk(16, "async rst", 32'(cfg[2].io.out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0);
    idle(20);
    repeat (300) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    idle(20);
    chk(4, "drained", cfg[0].q.size(), 0);
    chk(1, "drained", cfg[1].q.size(), 0);
    chk(16, "drained", cfg[2].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
